// File: rtl/key_cond_if.sv
// key_cond_if -- key bundle between the push-button pins and CONTROL.
//   nBIN  : raw asynchronous push-buttons, active-low,
//           bit order {SEL[2:0], DEC, CLR, QUE, READY}
//   BOUT  : one-CLK press pulses, same bit order as nBIN
//   LEVEL : debounced key state, 1 = pressed
// master drives the buttons (board/bench), slave is key_cond.
interface key_cond_if;
   logic [6:0] nBIN;
   logic [6:0] BOUT;
   logic [6:0] LEVEL;

   modport master (output nBIN, input BOUT, input LEVEL);
   modport slave  (input nBIN, output BOUT, output LEVEL);
endinterface

// File: rtl/key_cond.sv
// key_cond -- push-button conditioner: synchronise, debounce on a slow
// sample tick, and emit a one-CLK pulse per accepted press.
//   CLK  : system clock, rising edge
//   RST  : synchronous, active-high reset
//   kif  : key_cond_if.slave (nBIN in, BOUT / LEVEL out)
// Parameters: TICK_DIV (CLK cycles per sample tick), DB_CNT (disagreeing
// ticks to accept a new level), REP_DLY / REP_PER (auto-repeat timing).
// Build option: define KEY_COND_REPEAT_EN to enable auto-repeat; without
// it the repeat counters do not exist and REP_DLY / REP_PER are inert.

// One key: two-flop synchroniser, debounce counter, press pulse.
module key_cond_lane #(
   parameter int DB_CNT  = 4,
   parameter int REP_DLY = 500,
   parameter int REP_PER = 150
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic nb,
   output logic level,
   output logic bout
);
   localparam int CW = $clog2(DB_CNT + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DB_CNT - 1);

   if (DB_CNT < 1 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_param
      $error("key_cond_lane: DB_CNT, REP_DLY and REP_PER must be >= 1");
   end

   logic          sync1, sync2;
   logic          s;
   logic          level_q;
   logic          rep_hit;
   logic [CW-1:0] c;

   assign s = ~sync2;

`ifdef KEY_COND_REPEAT_EN
   localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rcnt;
   logic [RW-1:0] rlast;
   logic          rph;   // 0: waiting for first repeat, 1: periodic

   assign rlast   = rph ? RW'(REP_PER - 1) : RW'(REP_DLY - 1);
   assign rep_hit = tick & level & (rcnt == rlast);

   always_ff @(posedge clk) begin
      if (rst || !level) begin
         rcnt <= '0;
         rph  <= 1'b0;
      end else if (tick) begin
         if (rcnt == rlast) begin
            rcnt <= '0;
            rph  <= 1'b1;
         end else begin
            rcnt <= rcnt + 1'b1;
         end
      end
   end
`else
   assign rep_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         c       <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         bout    <= 1'b0;
      end else begin
         sync1   <= nb;
         sync2   <= sync1;
         level_q <= level;
         // level_q lags level by one cycle, so the pulse lands the cycle
         // after LEVEL rises; releases never pulse.
         bout    <= (level & ~level_q) | rep_hit;
         if (tick) begin
            if (s == level) begin
               c <= '0;                 // agreeing sample restarts window
            end else if (c == C_LAST) begin
               level <= ~level;         // DB_CNT-th disagreeing tick
               c     <= '0;
            end else begin
               c <= c + 1'b1;
            end
         end
      end
   end
endmodule

module key_cond #(
   parameter int TICK_DIV = 50000,
   parameter int DB_CNT   = 4,
   parameter int REP_DLY  = 500,
   parameter int REP_PER  = 150
) (
   input  logic     CLK,
   input  logic     RST,
   key_cond_if.slave kif
);
   localparam int NUM_KEYS = 7;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   if (TICK_DIV < 1) begin : g_bad_div
      $error("key_cond: TICK_DIV must be >= 1");
   end

   logic [PW-1:0]       pcnt;
   logic                tick;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] bout;

   assign tick = (pcnt == P_LAST);

   always_ff @(posedge CLK) begin
      if (RST)       pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + 1'b1;
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_cond_lane #(
         .DB_CNT (DB_CNT),
         .REP_DLY(REP_DLY),
         .REP_PER(REP_PER)
      ) u_lane (
         .clk  (CLK),
         .rst  (RST),
         .tick (tick),
         .nb   (kif.nBIN[i]),
         .level(level[i]),
         .bout (bout[i])
      );
   end

   assign kif.LEVEL = level;
   assign kif.BOUT  = bout;
endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond -- bench for key_cond with TICK_DIV=4, DB_CNT=3, REP_DLY=5,
// REP_PER=2. A behavioural model (input history, tick = cycle count since
// reset mod TICK_DIV, run length of disagreeing ticks, held-tick count)
// predicts LEVEL and BOUT every cycle; scenario tasks add targeted checks.
module tb_key_cond;
   localparam int TD = 4, DB = 3, RD = 5, RP = 2;
`ifdef KEY_COND_REPEAT_EN
   localparam int EXP_HOLD_PULSES = 5;
`else
   localparam int EXP_HOLD_PULSES = 1;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   key_cond_if kif ();

   key_cond #(.TICK_DIV(TD), .DB_CNT(DB), .REP_DLY(RD), .REP_PER(RP)) dut (
      .CLK(CLK), .RST(RST), .kif(kif));

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state (values after the latest clock edge)
   logic [6:0] m_h1, m_h2;     // nBIN seen at the last two edges
   logic [6:0] m_lvl, m_lvl_prev, m_bout;
   int m_cyc;
   int m_run [7];
`ifdef KEY_COND_REPEAT_EN
   int m_held [7];
`endif

   // Drive one cycle, advance the model at the edge, return at the negedge.
   task automatic step(input logic [6:0] nb, input logic rst);
      logic [6:0] samp, lvl_old;
      bit tk, fire;
      kif.nBIN = nb;
      RST = rst;
      @(posedge CLK);
      if (rst) begin
         m_h1 = '1; m_h2 = '1; m_lvl = '0; m_lvl_prev = '0; m_bout = '0;
         m_cyc = 0;
         for (int i = 0; i < 7; i++) begin
            m_run[i] = 0;
`ifdef KEY_COND_REPEAT_EN
            m_held[i] = 0;
`endif
         end
      end else begin
         samp = ~m_h2;
         tk = ((m_cyc % TD) == TD - 1);
         m_cyc++;
         m_h2 = m_h1;
         m_h1 = nb;
         lvl_old = m_lvl;
         for (int i = 0; i < 7; i++) begin
            fire = 1'b0;
            if (tk) begin
               if (samp[i] != m_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DB) begin
                     m_lvl[i] = ~m_lvl[i];
                     m_run[i] = 0;
                  end
               end else m_run[i] = 0;
            end
`ifdef KEY_COND_REPEAT_EN
            if (!lvl_old[i]) m_held[i] = 0;
            else if (tk) begin
               m_held[i]++;
               fire = (m_held[i] == RD) ||
                      (m_held[i] > RD && ((m_held[i] - RD) % RP) == 0);
            end
`endif
            m_bout[i] = (lvl_old[i] & ~m_lvl_prev[i]) | fire;
         end
         m_lvl_prev = lvl_old;
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      step(7'h7F, 1'b1);
      step(7'h00, 1'b1);
      n_chk++;
      if (kif.LEVEL !== 7'h00 || kif.BOUT !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_held LEVEL=%b BOUT=%b expected 0/0", kif.LEVEL, kif.BOUT);
      end
      step(7'h7F, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(7'h7F, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
      end
   endtask

   task automatic test_clean_press();
      int pulses0 = 0, others = 0, first = -1;
      for (int k = 0; k < 30; k++) begin
         step(7'h7E, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL clean_press k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT[0]) begin pulses0++; if (first < 0) first = k; end
         if (kif.BOUT[6:1] != 0) others++;
      end
      n_chk++;
      if (pulses0 != 1 || others != 0 || kif.LEVEL !== 7'h01) begin
         n_fail++;
         $display("FAIL clean_count pulses=%0d others=%0d LEVEL=%b expected 1 0 0000001", pulses0, others, kif.LEVEL);
      end
      n_chk++;
      if (first < 0 || first > 2 + DB * TD) begin
         n_fail++;
         $display("FAIL clean_latency first=%0d expected <= %0d", first, 2 + DB * TD);
      end
      for (int k = 0; k < 25; k++) begin
         step(7'h7F, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL clean_release k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
      end
   endtask

   task automatic test_bounce();
      int early = 0, total = 0;
      for (int k = 0; k < 52; k++) begin
         // low 2 ticks, high 1 tick, then low
         step((k >= 8 && k < 12) ? 7'h7F : 7'h77, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL bounce k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT[3]) begin total++; if (k < 22) early++; end
      end
      n_chk++;
      if (early != 0 || total != 1) begin
         n_fail++;
         $display("FAIL bounce_count early=%0d total=%0d expected 0 1", early, total);
      end
      for (int k = 0; k < 25; k++) step(7'h7F, 1'b0);
   endtask

   task automatic test_simultaneous();
      int pcyc = 0, rel = 0;
      logic [6:0] firstv = '0;
      for (int k = 0; k < 40; k++) begin
         step(7'b0001111, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL simul_press k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT != 0) begin if (pcyc == 0) firstv = kif.BOUT; pcyc++; end
      end
      n_chk++;
      if (firstv !== 7'b1110000 || kif.LEVEL !== 7'b1110000) begin
         n_fail++;
         $display("FAIL simul_vector BOUT=%b LEVEL=%b expected 1110000 1110000", firstv, kif.LEVEL);
      end
`ifndef KEY_COND_REPEAT_EN
      n_chk++;
      if (pcyc != 1) begin
         n_fail++;
         $display("FAIL simul_once pulse_cycles=%0d expected 1", pcyc);
      end
`endif
      for (int k = 0; k < 20; k++) begin
         step(7'h7F, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL simul_release k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT != 0) rel++;
      end
`ifndef KEY_COND_REPEAT_EN
      n_chk++;
      if (rel != 0) begin
         n_fail++;
         $display("FAIL release_pulse cycles=%0d expected 0", rel);
      end
`endif
      n_chk++;
      if (kif.LEVEL !== 7'h00) begin
         n_fail++;
         $display("FAIL release_level LEVEL=%b expected 0000000", kif.LEVEL);
      end
   endtask

   task automatic test_reset_mid();
      int first = -1, total = 0;
      for (int k = 0; k < 10; k++) step(7'b1111101, 1'b0);
      step(7'b1111101, 1'b1);
      n_chk++;
      if (kif.LEVEL !== 7'h00 || kif.BOUT !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_mid LEVEL=%b BOUT=%b expected 0/0", kif.LEVEL, kif.BOUT);
      end
      for (int k = 0; k < 24; k++) begin
         step(7'b1111101, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL reset_mid_run k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT[1]) begin total++; if (first < 0) first = k; end
      end
      n_chk++;
      if (first != DB * TD || total != 1) begin
         n_fail++;
         $display("FAIL reset_mid_pulse at=%0d count=%0d expected %0d 1", first, total, DB * TD);
      end
      for (int k = 0; k < 25; k++) step(7'h7F, 1'b0);
   endtask

   task automatic test_repeat();
      int total = 0;
      for (int k = 0; k < 62; k++) begin
         step(7'b1111011, 1'b0);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL repeat k=%0d LEVEL=%b BOUT=%b expected %b %b", k, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
         if (kif.BOUT[2]) total++;
      end
      n_chk++;
      if (total != EXP_HOLD_PULSES) begin
         n_fail++;
         $display("FAIL repeat_count pulses=%0d expected %0d", total, EXP_HOLD_PULSES);
      end
      for (int k = 0; k < 25; k++) step(7'h7F, 1'b0);
   endtask

   task automatic test_random();
      logic [6:0] nb = 7'h7F;
      logic r;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < 7; i++)
            if ($urandom_range(0, 19) == 0) nb[i] = ~nb[i];
         r = ($urandom_range(0, 299) == 0);
         step(nb, r);
         n_chk++;
         if ({kif.LEVEL, kif.BOUT} !== {m_lvl, m_bout}) begin
            n_fail++;
            $display("FAIL random k=%0d nBIN=%b LEVEL=%b BOUT=%b expected %b %b", k, nb, kif.LEVEL, kif.BOUT, m_lvl, m_bout);
         end
      end
   endtask

   initial begin
      kif.nBIN = 7'h7F;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/key_cond.md
KEY_COND -- requirements
Module: key_cond

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, the number of CLK cycles per debounce sample tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter DB_CNT, default 4, the number of consecutive disagreeing ticks needed to accept a new key level.
REQ-003 SHALL have parameter REP_DLY, default 500, the number of ticks a key is held before the first auto-repeat pulse (used only when the repeat macro is defined).
REQ-004 SHALL have parameter REP_PER, default 150, the number of ticks between later auto-repeat pulses (used only when the repeat macro is defined).
REQ-005 SHALL have port CLK, input, 1 bit: the single system clock, rising-edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port nBIN, input, 7 bits: raw asynchronous push-buttons, active-low, bit order {SEL[2:0], DEC, CLR, QUE, READY}.
REQ-008 SHALL have port BOUT, output, 7 bits: one-CLK press pulses, same bit order as nBIN, feeding CONTROL SEL/DEC/CLR/QUE/READY.
REQ-009 SHALL have port LEVEL, output, 7 bits: debounced key state, 1 = pressed.

Function
REQ-010 SHALL pass each nBIN bit through a two-flop synchroniser, then invert it, to give the sample S[i] (1 = pressed).
REQ-011 SHALL run a prescaler that counts 0..TICK_DIV-1, asserts TICK in the cycle the count equals TICK_DIV-1, and wraps to 0 on the next cycle.
REQ-012 SHALL keep a per-key counter C[i] of width clog2(DB_CNT+1) that changes only on TICK cycles.
REQ-013 SHALL, on TICK, clear C[i] to 0 if S[i]==LEVEL[i]; otherwise increment C[i].
REQ-014 SHALL, on the TICK where C[i] would reach DB_CNT, toggle LEVEL[i] and clear C[i] instead; a new level is accepted after exactly DB_CNT consecutive disagreeing ticks.
REQ-015 SHALL restart the count whenever a bounce (any agreeing sample) occurs inside the window, and SHALL NOT change LEVEL on it.
REQ-016 SHALL register BOUT[i] high for exactly one CLK cycle, in the cycle after LEVEL[i] goes 0->1.
REQ-017 SHALL generate no pulse on release (1->0).
REQ-018 SHALL process the 7 keys independently; simultaneous presses give simultaneous pulses with no priority or masking.
REQ-019 SHALL make worst-case press-to-pulse latency 2 sync cycles + DB_CNT*TICK_DIV + 1 cycles.
REQ-020 SHALL pulse at most once per accepted press while the repeat macro is undefined, regardless of hold time.

Reset
REQ-021 SHALL, on RST high at a CLK edge, set synchroniser flops to 1 (released), prescaler to 0, all C[i] to 0, LEVEL to 0, BOUT to 0, and all repeat counters to 0.
REQ-022 SHALL have a reset that overrides all other activity, including a debounce window or repeat in progress; no pulse is emitted in the cycle RST is high.
REQ-023 SHALL treat a key held through reset release as a new press, pulsing after DB_CNT ticks.

Configuration
REQ-024 SHALL implement auto-repeat when macro KEY_COND_REPEAT_EN is defined: while LEVEL[i]=1, a per-key tick counter runs; BOUT[i] pulses once more at REP_DLY ticks after acceptance, then every REP_PER ticks, and the counter clears on release.
REQ-025 SHALL, when KEY_COND_REPEAT_EN is undefined, contain no repeat counters, and REP_DLY and REP_PER SHALL have no effect.

Verification (TICK_DIV=4, DB_CNT=3, REP_DLY=5, REP_PER=2)
REQ-026 Clean press: nBIN[0] held low from cycle 10 -> LEVEL[0] rises after 3 ticks; BOUT[0] is high for 1 cycle only; BOUT[6:1] stays 0.
REQ-027 Bounce: nBIN[3] low for 2 ticks, high for 1 tick, then low -> no pulse until 3 further consecutive low ticks, then a single BOUT[3] pulse.
REQ-028 Release and simultaneous press: nBIN=7'b0001111 held for 10 ticks, then 7'h7F -> BOUT=7'b1110000 for one cycle; release produces no pulse; LEVEL returns to 0 after 3 ticks.
REQ-029 Reset mid-window: RST asserted for 1 cycle after 2 low ticks on nBIN[1] -> LEVEL and BOUT are 0; a pulse follows 3 ticks after reset.
REQ-030 Repeat: with KEY_COND_REPEAT_EN, nBIN[2] held low for 12 ticks after acceptance -> BOUT[2] pulses at acceptance and at +5, +7, +9, +11 ticks; without the macro, exactly 1 pulse.
